// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared definitions for the two-port CPU bus arbiter: FSM encoding,
// port indices and the default response timeout.
package rv32_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_B = 3'd2,
    ST_BUSY_A  = 3'd3,
    ST_BUSY_B  = 3'd4
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int TMO_CYCLES_DEFAULT = 255;

  // A request is any read or write strobe; write wins when both are seen.
  function automatic logic req_strobe(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/rv32_bus_arb_pend.sv
// Per-port pending-request flag: captures single-cycle strobes, merges
// repeats, clears on issue and ignores strobes while the port owns the bus.
module rv32_bus_arb_pend
  import rv32_bus_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_re,
  input  logic i_we,
  input  logic i_clr,
  input  logic i_ignore,
  output logic o_pend_eff,
  output logic o_pend_we
);

  logic pend_r;
  logic pend_we_r;
  logic strobe_s;

  assign strobe_s = req_strobe(i_re, i_we);

  // Pending flag register; clear-on-issue has priority over a new strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_r    <= 1'b0;
      pend_we_r <= 1'b0;
    end else if (i_clr) begin
      pend_r    <= 1'b0;
      pend_we_r <= 1'b0;
    end else if (!i_ignore && strobe_s) begin
      pend_r    <= 1'b1;
      pend_we_r <= i_we;
    end
  end

  // Effective pending view includes a strobe arriving in this cycle.
  assign o_pend_eff = pend_r | (strobe_s & ~i_clr & ~i_ignore);
  assign o_pend_we  = pend_we_r;

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Two-port CPU bus arbiter (A = LSU, B = fetch): latches request strobes,
// issues one bus strobe per grant, routes the response and enforces a timeout.
module rv32_bus_arbiter
  import rv32_bus_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int TMO_CYCLES  = TMO_CYCLES_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_a_req_addr,
  input  logic [XLEN-1:0] i_a_req_data,
  input  logic [3:0]      i_a_req_ben,
  input  logic            i_a_req_re,
  input  logic            i_a_req_we,
  input  logic            i_a_req_src,
  input  logic            i_a_req_priv,
  input  logic            i_a_req_rvso,
  output logic [XLEN-1:0] o_a_rsp_data,
  output logic            o_a_rsp_ack,
  output logic            o_a_rsp_err,
  input  logic [XLEN-1:0] i_b_req_addr,
  input  logic [XLEN-1:0] i_b_req_data,
  input  logic [3:0]      i_b_req_ben,
  input  logic            i_b_req_re,
  input  logic            i_b_req_we,
  input  logic            i_b_req_src,
  input  logic            i_b_req_priv,
  input  logic            i_b_req_rvso,
  output logic [XLEN-1:0] o_b_rsp_data,
  output logic            o_b_rsp_ack,
  output logic            o_b_rsp_err,
  output logic [XLEN-1:0] o_bus_req_addr,
  output logic [XLEN-1:0] o_bus_req_data,
  output logic [3:0]      o_bus_req_ben,
  output logic            o_bus_req_re,
  output logic            o_bus_req_we,
  output logic            o_bus_req_src,
  output logic            o_bus_req_priv,
  output logic            o_bus_req_rvso,
  input  logic [XLEN-1:0] i_bus_rsp_data,
  input  logic            i_bus_rsp_ack,
  input  logic            i_bus_rsp_err,
  output logic            o_arb_busy
);

  localparam int            CW       = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  arb_state_e    state_r;
  arb_state_e    state_s;
  logic          rr_r;
  logic          rr_s;
  logic [CW-1:0] cnt_r;
  logic          a_pend_eff_s;
  logic          a_pend_we_s;
  logic          b_pend_eff_s;
  logic          b_pend_we_s;
  logic          tmo_hit_s;
  logic          done_s;
  logic          grant_a_s;
  logic          grant_b_s;

  rv32_bus_arb_pend u_pend_a (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_re       (i_a_req_re),
    .i_we       (i_a_req_we),
    .i_clr      (state_r == ST_ISSUE_A),
    .i_ignore   (state_r == ST_BUSY_A),
    .o_pend_eff (a_pend_eff_s),
    .o_pend_we  (a_pend_we_s)
  );

  rv32_bus_arb_pend u_pend_b (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_re       (i_b_req_re),
    .i_we       (i_b_req_we),
    .i_clr      (state_r == ST_ISSUE_B),
    .i_ignore   (state_r == ST_BUSY_B),
    .o_pend_eff (b_pend_eff_s),
    .o_pend_we  (b_pend_we_s)
  );

  assign tmo_hit_s = (cnt_r == TMO_LAST);
  assign done_s    = i_bus_rsp_ack | i_bus_rsp_err | tmo_hit_s;
  assign grant_a_s = (state_r == ST_ISSUE_A) || (state_r == ST_BUSY_A);
  assign grant_b_s = (state_r == ST_ISSUE_B) || (state_r == ST_BUSY_B);

  // FSM state and round-robin pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      rr_r    <= PORT_A;
    end else begin
      state_r <= state_s;
      rr_r    <= rr_s;
    end
  end

  // Timeout counter: cycles spent waiting for a response, zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_BUSY_A) || (state_r == ST_BUSY_B)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_s = state_r;
    rr_s    = rr_r;
    case (state_r)
      ST_IDLE: begin
        if (a_pend_eff_s && b_pend_eff_s) begin
          if (ROUND_ROBIN != 0) begin
            state_s = (rr_r == PORT_B) ? ST_ISSUE_B : ST_ISSUE_A;
            rr_s    = (rr_r == PORT_A) ? PORT_B : PORT_A;
          end else begin
            state_s = ST_ISSUE_A;
          end
        end else if (a_pend_eff_s) begin
          state_s = ST_ISSUE_A;
        end else if (b_pend_eff_s) begin
          state_s = ST_ISSUE_B;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE_A: state_s = ST_BUSY_A;
      ST_ISSUE_B: state_s = ST_BUSY_B;
      ST_BUSY_A: begin
        if (done_s) begin
          state_s = b_pend_eff_s ? ST_ISSUE_B : ST_IDLE;
        end else begin
          state_s = ST_BUSY_A;
        end
      end
      ST_BUSY_B: begin
        if (done_s) begin
          state_s = a_pend_eff_s ? ST_ISSUE_A : ST_IDLE;
        end else begin
          state_s = ST_BUSY_B;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus strobes and response routing; a real ack masks the timeout error.
  always_comb begin
    o_bus_req_re = 1'b0;
    o_bus_req_we = 1'b0;
    o_a_rsp_ack  = 1'b0;
    o_a_rsp_err  = 1'b0;
    o_a_rsp_data = {XLEN{1'b0}};
    o_b_rsp_ack  = 1'b0;
    o_b_rsp_err  = 1'b0;
    o_b_rsp_data = {XLEN{1'b0}};
    o_arb_busy   = (state_r != ST_IDLE);
    case (state_r)
      ST_ISSUE_A: begin
        o_bus_req_re = ~a_pend_we_s;
        o_bus_req_we = a_pend_we_s;
      end
      ST_ISSUE_B: begin
        o_bus_req_re = ~b_pend_we_s;
        o_bus_req_we = b_pend_we_s;
      end
      ST_BUSY_A: begin
        o_a_rsp_ack  = i_bus_rsp_ack;
        o_a_rsp_err  = i_bus_rsp_err | (tmo_hit_s & ~i_bus_rsp_ack);
        o_a_rsp_data = i_bus_rsp_data;
      end
      ST_BUSY_B: begin
        o_b_rsp_ack  = i_bus_rsp_ack;
        o_b_rsp_err  = i_bus_rsp_err | (tmo_hit_s & ~i_bus_rsp_ack);
        o_b_rsp_data = i_bus_rsp_data;
      end
      default: begin
        o_arb_busy = 1'b0;
      end
    endcase
  end

  // Payload mux from the granted port; all zero while idle.
  always_comb begin
    if (grant_a_s) begin
      o_bus_req_addr = i_a_req_addr;
      o_bus_req_data = i_a_req_data;
      o_bus_req_ben  = i_a_req_ben;
      o_bus_req_src  = i_a_req_src;
      o_bus_req_priv = i_a_req_priv;
      o_bus_req_rvso = i_a_req_rvso;
    end else if (grant_b_s) begin
      o_bus_req_addr = i_b_req_addr;
      o_bus_req_data = i_b_req_data;
      o_bus_req_ben  = i_b_req_ben;
      o_bus_req_src  = i_b_req_src;
      o_bus_req_priv = i_b_req_priv;
      o_bus_req_rvso = i_b_req_rvso;
    end else begin
      o_bus_req_addr = {XLEN{1'b0}};
      o_bus_req_data = {XLEN{1'b0}};
      o_bus_req_ben  = 4'b0000;
      o_bus_req_src  = 1'b0;
      o_bus_req_priv = 1'b0;
      o_bus_req_rvso = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: two instances (fixed priority and round robin,
// timeout 4) share stimulus; directed table, corner sequences, random + model.
module tb_rv32_bus_arbiter;

  localparam int TMO = 4;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0000_1004;
  localparam logic [31:0] AW = 32'h0000_2000;
  localparam logic [31:0] BR = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, bus_rdata;
  logic [3:0]  a_ben, b_ben;
  logic a_re, a_we, a_src, a_priv, a_rvso;
  logic b_re, b_we, b_src, b_priv, b_rvso;
  logic bus_ack, bus_err;

  logic [31:0] bus_addr [2];
  logic [31:0] bus_wdata [2];
  logic [3:0]  bus_ben [2];
  logic [31:0] a_rdata [2];
  logic [31:0] b_rdata [2];
  logic bus_re [2];
  logic bus_we [2];
  logic bus_src [2];
  logic bus_priv [2];
  logic bus_rvso [2];
  logic a_ack [2];
  logic a_err [2];
  logic b_ack [2];
  logic b_err [2];
  logic busy [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    rv32_bus_arbiter #(.XLEN(32), .ROUND_ROBIN(k), .TMO_CYCLES(TMO)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_req_addr(a_addr), .i_a_req_data(a_wdata), .i_a_req_ben(a_ben),
      .i_a_req_re(a_re), .i_a_req_we(a_we), .i_a_req_src(a_src),
      .i_a_req_priv(a_priv), .i_a_req_rvso(a_rvso),
      .o_a_rsp_data(a_rdata[k]), .o_a_rsp_ack(a_ack[k]), .o_a_rsp_err(a_err[k]),
      .i_b_req_addr(b_addr), .i_b_req_data(b_wdata), .i_b_req_ben(b_ben),
      .i_b_req_re(b_re), .i_b_req_we(b_we), .i_b_req_src(b_src),
      .i_b_req_priv(b_priv), .i_b_req_rvso(b_rvso),
      .o_b_rsp_data(b_rdata[k]), .o_b_rsp_ack(b_ack[k]), .o_b_rsp_err(b_err[k]),
      .o_bus_req_addr(bus_addr[k]), .o_bus_req_data(bus_wdata[k]),
      .o_bus_req_ben(bus_ben[k]), .o_bus_req_re(bus_re[k]), .o_bus_req_we(bus_we[k]),
      .o_bus_req_src(bus_src[k]), .o_bus_req_priv(bus_priv[k]),
      .o_bus_req_rvso(bus_rvso[k]),
      .i_bus_rsp_data(bus_rdata), .i_bus_rsp_ack(bus_ack), .i_bus_rsp_err(bus_err),
      .o_arb_busy(busy[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [141:0] get_out(input int k);
    return {bus_addr[k], bus_wdata[k], bus_ben[k], bus_re[k], bus_we[k], bus_src[k],
            bus_priv[k], bus_rvso[k], a_rdata[k], a_ack[k], a_err[k],
            b_rdata[k], b_ack[k], b_err[k], busy[k]};
  endfunction

  // ---------------- reference model (one per instance) ----------------
  // owner: 0 nobody, 1 port A, 2 port B; issuing: bus strobe cycle.
  int  owner [2];
  bit  issuing [2];
  int  issue_cyc [2];
  bit  pend [2][2];
  bit  pwe [2][2];
  int  rr [2];
  int  cyc = 0;
  bit  model_valid = 1'b0;

  function automatic logic [141:0] model_exp(input int k);
    logic [31:0] ad, wd, rda, rdb;
    logic [3:0]  be;
    logic re, we, sr, pv, rv, aa, ae, ba, bea, bz, e;
    int x;
    ad = Z; wd = Z; rda = Z; rdb = Z; be = 4'h0;
    re = 1'b0; we = 1'b0; sr = 1'b0; pv = 1'b0; rv = 1'b0;
    aa = 1'b0; ae = 1'b0; ba = 1'b0; bea = 1'b0; bz = 1'b0;
    if (owner[k] != 0) begin
      x  = owner[k] - 1;
      bz = 1'b1;
      if (x == 0) begin
        ad = a_addr; wd = a_wdata; be = a_ben; sr = a_src; pv = a_priv; rv = a_rvso;
      end else begin
        ad = b_addr; wd = b_wdata; be = b_ben; sr = b_src; pv = b_priv; rv = b_rvso;
      end
      if (issuing[k]) begin
        re = !pwe[k][x];
        we = pwe[k][x];
      end else begin
        e = bus_err | ((cyc - issue_cyc[k] == TMO) && !bus_ack);
        if (x == 0) begin
          aa = bus_ack; ae = e; rda = bus_rdata;
        end else begin
          ba = bus_ack; bea = e; rdb = bus_rdata;
        end
      end
    end
    return {ad, wd, be, re, we, sr, pv, rv, rda, aa, ae, rdb, ba, bea, bz};
  endfunction

  function automatic void model_step();
    bit st [2];
    bit wv [2];
    int x, o, g;
    st[0] = a_re | a_we; wv[0] = a_we;
    st[1] = b_re | b_we; wv[1] = b_we;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner[k] = 0; issuing[k] = 1'b0; rr[k] = 0;
        for (int p = 0; p < 2; p++) begin pend[k][p] = 1'b0; pwe[k][p] = 1'b0; end
      end else if (owner[k] == 0) begin
        for (int p = 0; p < 2; p++)
          if (st[p]) begin pend[k][p] = 1'b1; pwe[k][p] = wv[p]; end
        if (pend[k][0] && pend[k][1]) begin
          g = (k == 1) ? rr[k] : 0;
          if (k == 1) rr[k] = 1 - g;
          owner[k] = g + 1; issuing[k] = 1'b1;
        end else if (pend[k][0] || pend[k][1]) begin
          owner[k] = pend[k][0] ? 1 : 2; issuing[k] = 1'b1;
        end
      end else begin
        x = owner[k] - 1;
        o = 1 - x;
        if (st[o]) begin pend[k][o] = 1'b1; pwe[k][o] = wv[o]; end
        if (issuing[k]) begin
          pend[k][x] = 1'b0; issuing[k] = 1'b0; issue_cyc[k] = cyc;
        end else if (bus_ack || bus_err || (cyc - issue_cyc[k] == TMO)) begin
          if (pend[k][o]) begin owner[k] = o + 1; issuing[k] = 1'b1; end
          else owner[k] = 0;
        end
      end
    end
    if (rst) model_valid = 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (get_out(k) !== model_exp(k)) begin
            errors++;
            $display("FAIL model dut%0d cyc %0d: got %0h expected %0h",
                     k, cyc, get_out(k), model_exp(k));
          end
        end
      end
      model_step();
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic a_re, a_we; logic [31:0] a_addr;
    logic b_re, b_we; logic [31:0] b_addr;
    logic ack; logic [31:0] rdata;
    logic e_re, e_we; logic [31:0] e_addr;
    logic e_a_ack; logic [31:0] e_a_data; logic e_b_ack; logic e_busy;
    logic e1_re, e1_we; logic [31:0] e1_addr;
  } vec_t;

  vec_t tbl [18];

  task automatic clear_inputs();
    a_addr = Z; a_wdata = Z; a_ben = 4'h0; a_re = L; a_we = L; a_src = L; a_priv = L; a_rvso = L;
    b_addr = Z; b_wdata = Z; b_ben = 4'h0; b_re = L; b_we = L; b_src = L; b_priv = L; b_rvso = L;
    bus_rdata = Z; bus_ack = L; bus_err = L;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_re, n_busy;

  initial begin
    // single read, then two fixed-priority conflicts (round robin differs on the second)
    tbl[0]  = '{H,L,A1, L,L,Z,  L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};
    tbl[1]  = '{L,L,A1, L,L,Z,  L,Z,            H,L,A1, L,Z,L,H,             H,L,A1};
    tbl[2]  = '{L,L,A1, L,L,Z,  L,Z,            L,L,A1, L,Z,L,H,             L,L,A1};
    tbl[3]  = '{L,L,A1, L,L,Z,  L,Z,            L,L,A1, L,Z,L,H,             L,L,A1};
    tbl[4]  = '{L,L,A1, L,L,Z,  H,32'hDEADBEEF, L,L,A1, H,32'hDEADBEEF,L,H,  L,L,A1};
    tbl[5]  = '{L,L,Z,  L,L,Z,  L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};
    tbl[6]  = '{L,H,AW, H,L,BR, L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};
    tbl[7]  = '{L,L,AW, L,L,BR, L,Z,            L,H,AW, L,Z,L,H,             L,H,AW};
    tbl[8]  = '{L,L,AW, L,L,BR, H,32'h55,       L,L,AW, H,32'h55,L,H,        L,L,AW};
    tbl[9]  = '{L,L,AW, L,L,BR, L,Z,            H,L,BR, L,Z,L,H,             H,L,BR};
    tbl[10] = '{L,L,AW, L,L,BR, H,32'h12345678, L,L,BR, L,Z,H,H,             L,L,BR};
    tbl[11] = '{L,L,Z,  L,L,Z,  L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};
    tbl[12] = '{L,H,AW, H,L,BR, L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};
    tbl[13] = '{L,L,AW, L,L,BR, L,Z,            L,H,AW, L,Z,L,H,             H,L,BR};
    tbl[14] = '{L,L,AW, L,L,BR, H,32'h66,       L,L,AW, H,32'h66,L,H,        L,L,BR};
    tbl[15] = '{L,L,AW, L,L,BR, L,Z,            H,L,BR, L,Z,L,H,             L,H,AW};
    tbl[16] = '{L,L,AW, L,L,BR, H,32'h12345678, L,L,BR, L,Z,H,H,             L,L,AW};
    tbl[17] = '{L,L,Z,  L,L,Z,  L,Z,            L,L,Z,  L,Z,L,L,             L,L,Z};

    clear_inputs();
    rst = H;
    repeat (3) tick();
    rst = L;
    @(negedge clk);
    check("reset dut0", 160'(get_out(0)), 160'(0));
    check("reset dut1", 160'(get_out(1)), 160'(0));
    tick();

    for (int i = 0; i < 18; i++) begin
      a_re = tbl[i].a_re; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr;
      b_re = tbl[i].b_re; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr;
      bus_ack = tbl[i].ack; bus_rdata = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("row%0d bus0", i), 160'({bus_re[0], bus_we[0], bus_addr[0]}),
            160'({tbl[i].e_re, tbl[i].e_we, tbl[i].e_addr}));
      check($sformatf("row%0d rsp0", i), 160'({a_ack[0], a_rdata[0], b_ack[0]}),
            160'({tbl[i].e_a_ack, tbl[i].e_a_data, tbl[i].e_b_ack}));
      check($sformatf("row%0d busy0", i), 160'(busy[0]), 160'(tbl[i].e_busy));
      check($sformatf("row%0d bus1", i), 160'({bus_re[1], bus_we[1], bus_addr[1]}),
            160'({tbl[i].e1_re, tbl[i].e1_we, tbl[i].e1_addr}));
      tick();
    end

    // timeout on B: error exactly TMO cycles after the bus strobe, late ack dropped
    clear_inputs();
    b_re = H; b_addr = 32'h0000_0300;
    tick();
    b_re = L;
    for (int c = 1; c <= 6; c++) begin
      bus_ack = (c == 6);
      @(negedge clk);
      if (c == 1) check("tmo strobe", 160'(bus_re[0]), 160'(1));
      if (c == 4) check("tmo early", 160'(b_err[0]), 160'(0));
      if (c == 5) check("tmo err", 160'({b_err[0], a_err[0]}), 160'(2'b10));
      if (c == 6) check("tmo late ack", 160'({b_ack[0], busy[0]}), 160'(0));
      tick();
    end

    // ack on the timeout cycle: ack only
    clear_inputs();
    a_re = H; a_addr = 32'h0000_3000;
    tick();
    a_re = L;
    for (int c = 1; c <= 6; c++) begin
      bus_ack = (c == 5);
      @(negedge clk);
      if (c == 5) check("ack at tmo", 160'({a_ack[0], a_err[0]}), 160'(2'b10));
      if (c == 6) check("ack at tmo idle", 160'(busy[0]), 160'(0));
      tick();
    end

    // repeated strobe from the granted port while busy is ignored
    clear_inputs();
    a_re = H; a_addr = 32'h0000_4000;
    tick();
    n_re = 0; n_busy = 0;
    for (int c = 1; c <= 6; c++) begin
      a_re = (c == 2);
      bus_ack = (c == 3);
      @(negedge clk);
      n_re += int'(bus_re[0]);
      if (c >= 4) n_busy += int'(busy[0]);
      tick();
    end
    check("ignored strobe count", 160'(n_re), 160'(1));
    check("ignored strobe idle", 160'(n_busy), 160'(0));

    // reset while A is busy and B is pending
    clear_inputs();
    a_re = H; a_addr = 32'h0000_5000;
    tick();
    a_re = L; b_re = H; b_addr = 32'h0000_0600;
    tick();
    b_re = L; rst = H;
    tick();
    rst = L; bus_ack = H;
    @(negedge clk);
    check("reset mid dut0", 160'(get_out(0)), 160'(0));
    check("reset mid dut1", 160'(get_out(1)), 160'(0));
    tick();
    bus_ack = L;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("reset lost pend %0d", c), 160'({bus_re[0], bus_we[0], busy[0]}), 160'(0));
      tick();
    end

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      a_re = ($urandom_range(0, 5) == 0); a_we = ($urandom_range(0, 7) == 0);
      b_re = ($urandom_range(0, 5) == 0); b_we = ($urandom_range(0, 7) == 0);
      a_addr = $urandom; a_wdata = $urandom; a_ben = 4'($urandom);
      b_addr = $urandom; b_wdata = $urandom; b_ben = 4'($urandom);
      a_src = 1'($urandom); a_priv = 1'($urandom); a_rvso = 1'($urandom);
      b_src = 1'($urandom); b_priv = 1'($urandom); b_rvso = 1'($urandom);
      bus_rdata = $urandom;
      bus_ack = ($urandom_range(0, 3) == 0);
      bus_err = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear_inputs();
    rst = L;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
- Shares the single CPU bus between two requesters: port A (LSU data access) and port B (instruction fetch).
- Requests arrive as single-cycle re/we strobes. The arbiter latches pending strobes, grants one port at a time and issues a one-cycle strobe on the shared bus.
- Routes ack/err/data back to the granted port only.
- Generates a bus error if no response arrives within a timeout window.

Parameters:
- XLEN, 32, data/address width
- ROUND_ROBIN, 0, 0 = port A has fixed priority on conflict; 1 = alternate priority on conflict
- TMO_CYCLES, 255, maximum cycles from bus strobe to ack before forced error (minimum 2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_a_req_addr / i_a_req_data  in  XLEN  port A address / write data
- i_a_req_ben  in  4  port A byte enable
- i_a_req_re / i_a_req_we  in  1  port A read / write strobe (single cycle)
- i_a_req_src / i_a_req_priv / i_a_req_rvso  in  1  port A source / privilege / reservation-set attributes
- o_a_rsp_data  out  XLEN  port A read data
- o_a_rsp_ack / o_a_rsp_err  out  1  port A acknowledge / error
- i_b_req_* and o_b_rsp_*: same set and widths for port B
- o_bus_req_addr / o_bus_req_data  out  XLEN  shared bus address / write data
- o_bus_req_ben  out  4  shared bus byte enable
- o_bus_req_re / o_bus_req_we  out  1  shared bus strobes
- o_bus_req_src / o_bus_req_priv / o_bus_req_rvso  out  1  shared bus attributes
- i_bus_rsp_data  in  XLEN  bus read data
- i_bus_rsp_ack / i_bus_rsp_err  in  1  bus acknowledge / error
- o_arb_busy  out  1  transaction in flight

Behaviour:
- Reset: state IDLE, pending flags 0, timeout counter 0, RR pointer = A. All outputs 0.
- Pending flags:
  - Per port: pend (1 bit) and pend_we (1 bit).
  - A strobe re|we sets pend and loads pend_we = we.
  - re and we together is illegal; we wins.
  - A strobe while pend is already set merges and overwrites pend_we.
  - A strobe from the port currently in BUSY is ignored.
- Payload: requesters hold addr/data/ben/attributes stable from their strobe until their ack/err. The arbiter muxes the payload from the granted port combinationally. In IDLE, payload outputs are 0.
- FSM states: IDLE, ISSUE_A, ISSUE_B, BUSY_A, BUSY_B.
- IDLE:
  - Evaluates pending flags, including a strobe arriving this cycle.
  - If only one port is pending, go to ISSUE_x.
  - If both are pending: ROUND_ROBIN = 0 selects A; ROUND_ROBIN = 1 selects the port indicated by the RR pointer, and the pointer flips to the other port after the grant.
- ISSUE_x:
  - o_bus_req_re = !pend_we or o_bus_req_we = pend_we, for exactly one cycle.
  - Clears pend_x, counter = 0, go to BUSY_x.
  - Latency: strobe at cycle t in IDLE -> bus strobe at t+1.
- BUSY_x:
  - o_x_rsp_ack = i_bus_rsp_ack, o_x_rsp_err = i_bus_rsp_err, o_x_rsp_data = i_bus_rsp_data.
  - The other port sees ack = err = 0 and data = 0.
  - The counter increments each cycle.
  - On ack or err, go to IDLE. Back-to-back: if the other port is pending, go directly to ISSUE_other; its bus strobe appears the cycle after the ack.
  - If the counter reaches TMO_CYCLES-1 without ack/err, assert o_x_rsp_err for one cycle and go to IDLE/next ISSUE.
  - Ack and timeout in the same cycle: ack wins, no error.
  - ack and err together are forwarded as received.
- Responses outside BUSY: a late ack/err arriving in IDLE/ISSUE is dropped and not forwarded.
- Reset mid-transaction: abandons everything. No response is given to either port, and pending requests are lost.
- o_arb_busy = 1 in ISSUE_x and BUSY_x.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (5 states, 3 bits).
  - Port index constants (PORT_A = 0, PORT_B = 1).
  - Default TMO_CYCLES.
- One sub-module: rv32_bus_arb_pend, the per-port pending-flag register (strobe capture, merge, clear-on-issue, ignore-when-busy), instantiated twice.
- Timeout counter and FSM stay in the top module.

Test Plan:
- Single read: A re at cycle 10 -> o_bus_req_re = 1 at 11 with A's addr 0x00001004; bus ack at 14 with data 0xDEADBEEF -> o_a_rsp_ack = 1, o_a_rsp_data = 0xDEADBEEF at 14; o_b_rsp_ack = 0 throughout.
- Simultaneous strobes, ROUND_ROBIN = 0:
  - A we (addr 0x2000) and B re (addr 0x0100) at cycle 5 -> bus we at 6 (addr 0x2000).
  - Ack at 8 -> bus re at 9 (addr 0x0100).
  - Repeat -> A served first again.
- ROUND_ROBIN = 1: two consecutive simultaneous A/B conflicts -> first grant A, second grant B.
- Timeout, TMO_CYCLES = 4: B re, no ack -> o_b_rsp_err = 1 exactly 4 cycles after the bus strobe. A late ack one cycle later is not forwarded.
- Edge cases:
  - Ack coinciding with the timeout cycle -> ack only, err = 0.
  - Second strobe from the granted port during BUSY is ignored (only one bus strobe).
- Reset mid-BUSY_A with B pending -> all outputs 0 next cycle, no bus strobe afterwards, state IDLE.
